// File: rtl/ram1024x32_arbiter_pkg.sv
// Shared definitions for the two-port RAM1024x32 arbiter.
//   - Default address/data widths and RAM depth.
//   - Owner encoding (OWN_A / OWN_B), also used as the last-grant value.
//   - Width of the optional grant counters (RAM1024X32_ARBITER_STATS_EN).
//   - Sequencer FSM state enum.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 1024;
    localparam int unsigned STATS_W    = 16;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ram1024x32_arbiter_if.sv
// Requester-side bus of the RAM1024x32 arbiter (one instance per port).
//   req/we/addr/wdata : command, driven by the requester and held until ack
//   ack               : one-cycle completion pulse
//   rdata             : read data, valid with ack for reads
//   err               : out-of-range flag, valid with ack
// Modports: master = requester, slave = arbiter.
interface ram1024x32_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err
    );

endinterface

// File: rtl/ram1024x32_arbiter_rr_arb2.sv
// Two-input round-robin grant logic with its last-grant register.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_a, req_b : requests
//   upd          : record the current grant as last grant (when valid)
//   valid        : at least one request is present
//   own          : granted port (OWN_A / OWN_B)
// last_grant resets to OWN_B so port A wins the first tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    output logic valid,
    output logic own
);

    logic last_q;

    always_comb begin
        valid = req_a | req_b;
        if (req_a && req_b) begin
            own = ~last_q;
        end else if (req_b) begin
            own = OWN_B;
        end else begin
            own = OWN_A;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= OWN_B;
        end else if (upd && valid) begin
            last_q <= own;
        end
    end

endmodule

// File: rtl/ram1024x32_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port 1024x32 RAM.
//   clk, rst_n       : clock, synchronous active-low reset
//   port_a, port_b   : requester buses (ram1024x32_arbiter_if.slave)
//   ram_we/addr/din  : registered RAM controls
//   ram_dout         : RAM read data, valid RD_LAT cycles after the address edge
//   gnt_cnt_a/b      : saturating ack counters, only with RAM1024X32_ARBITER_STATS_EN
// Write ack arrives two cycles after the request is seen in IDLE, read ack 2+RD_LAT.
// Out-of-range commands never touch the RAM and complete with err=1, rdata=0.
module ram1024x32_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ram1024x32_arbiter_if.slave port_a,
    ram1024x32_arbiter_if.slave port_b,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
`ifdef RAM1024X32_ARBITER_STATS_EN
    ,
    output logic [STATS_W-1:0]  gnt_cnt_a,
    output logic [STATS_W-1:0]  gnt_cnt_b
`endif
);

    localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    arb_state_e          state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                own_q, own_d;
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic                err_a_q, err_a_d, err_b_q, err_b_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

    logic                gnt_valid, gnt_own, arb_upd;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (port_a.req),
        .req_b (port_b.req),
        .upd   (arb_upd),
        .valid (gnt_valid),
        .own   (gnt_own)
    );

    always_comb begin
        sel_we    = (gnt_own == OWN_B) ? port_b.we    : port_a.we;
        sel_addr  = (gnt_own == OWN_B) ? port_b.addr  : port_a.addr;
        sel_wdata = (gnt_own == OWN_B) ? port_b.wdata : port_a.wdata;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_d      = own_q;
        we_d       = we_q;
        oor_d      = oor_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        err_a_d    = 1'b0;
        err_b_d    = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        arb_upd    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    arb_upd    = 1'b1;
                    own_d      = gnt_own;
                    we_d       = sel_we;
                    oor_d      = ~in_range(sel_addr);
                    // RAM controls are registered, so load them now to be live during ISSUE.
                    ram_we_d   = sel_we & in_range(sel_addr);
                    ram_addr_d = sel_addr;
                    ram_din_d  = sel_wdata;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (oor_q || we_q) begin
                    state_d = RESP;
                    ack_a_d = (own_q == OWN_A);
                    ack_b_d = (own_q == OWN_B);
                    err_a_d = (own_q == OWN_A) & oor_q;
                    err_b_d = (own_q == OWN_B) & oor_q;
                    if (oor_q) begin
                        if (own_q == OWN_A) begin
                            rdata_a_d = '0;
                        end else begin
                            rdata_b_d = '0;
                        end
                    end
                end else begin
                    state_d = WAIT;
                    cnt_d   = CntW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    ack_a_d = (own_q == OWN_A);
                    ack_b_d = (own_q == OWN_B);
                    if (own_q == OWN_A) begin
                        rdata_a_d = ram_dout;
                    end else begin
                        rdata_b_d = ram_dout;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            RESP: begin
                // Requests are ignored here so a held req is not re-issued.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            own_q      <= OWN_A;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_q      <= own_d;
            we_q       <= we_d;
            oor_q      <= oor_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_din      = ram_din_q;
    assign port_a.ack   = ack_a_q;
    assign port_a.err   = err_a_q;
    assign port_a.rdata = rdata_a_q;
    assign port_b.ack   = ack_b_q;
    assign port_b.err   = err_b_q;
    assign port_b.rdata = rdata_b_q;

`ifdef RAM1024X32_ARBITER_STATS_EN
    logic [STATS_W-1:0] gnt_cnt_a_q, gnt_cnt_b_q;

    // Counted on the same edge that raises ack, so the count tracks visible acks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_cnt_a_q <= '0;
            gnt_cnt_b_q <= '0;
        end else begin
            if (ack_a_d && (gnt_cnt_a_q != '1)) begin
                gnt_cnt_a_q <= gnt_cnt_a_q + STATS_W'(1);
            end
            if (ack_b_d && (gnt_cnt_b_q != '1)) begin
                gnt_cnt_b_q <= gnt_cnt_b_q + STATS_W'(1);
            end
        end
    end

    assign gnt_cnt_a = gnt_cnt_a_q;
    assign gnt_cnt_b = gnt_cnt_b_q;
`endif

endmodule

// File: tb/tb_ram1024x32_arbiter.sv
// Self-checking bench for ram1024x32_arbiter: directed cases with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (grant order, fixed latencies, RAM contents).
module tb_ram1024x32_arbiter;

    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram1024x32_arbiter_if #(.ADDR_W(11), .DATA_W(32)) if_a ();
    ram1024x32_arbiter_if #(.ADDR_W(11), .DATA_W(32)) if_b ();

    logic        ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
`ifdef RAM1024X32_ARBITER_STATS_EN
    logic [15:0] gnt_cnt_a, gnt_cnt_b;
`endif

    ram1024x32_arbiter #(
        .ADDR_W (11),
        .DATA_W (32),
        .DEPTH  (1024),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .port_a    (if_a),
        .port_b    (if_b),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef RAM1024X32_ARBITER_STATS_EN
        ,
        .gnt_cnt_a (gnt_cnt_a),
        .gnt_cnt_b (gnt_cnt_b)
`endif
    );

    // Single-port RAM, one-cycle registered read, not affected by rst_n.
    logic [31:0] ram_mem [0:1023];
    logic        mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
        end else if (ram_we) begin
            ram_mem[ram_addr[9:0]] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr[9:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] model_mem [0:1023];
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_own, m_we, m_oor;
    logic [10:0] m_addr;
    logic [31:0] m_wdata, m_rdata_res;
    int          m_issue_cyc, m_ack_cyc;
    int          m_free_cyc = 0;
    logic [31:0] m_rdata_a = '0, m_rdata_b = '0;
    logic [10:0] m_hold_addr = '0;
    logic [31:0] m_hold_din = '0;
    int          m_cnt_a = 0, m_cnt_b = 0;
    bit          e_ack_a, e_ack_b, e_err_a, e_err_b, e_we, nb;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;
        forever begin
            @(negedge clk);
            e_ack_a = 1'b0; e_ack_b = 1'b0; e_err_a = 1'b0; e_err_b = 1'b0; e_we = 1'b0;
            if (m_busy && cyc == m_issue_cyc) begin
                m_hold_addr = m_addr;
                m_hold_din  = m_wdata;
                e_we        = m_we && !m_oor;
            end
            if (m_busy && cyc == m_ack_cyc) begin
                rd = m_oor ? 32'h0 : m_rdata_res;
                if (m_own) begin
                    e_ack_b = 1'b1; e_err_b = m_oor;
                    if (m_oor || !m_we) m_rdata_b = rd;
                    if (m_cnt_b < 16'hFFFF) m_cnt_b++;
                end else begin
                    e_ack_a = 1'b1; e_err_a = m_oor;
                    if (m_oor || !m_we) m_rdata_a = rd;
                    if (m_cnt_a < 16'hFFFF) m_cnt_a++;
                end
                m_busy     = 1'b0;
                m_free_cyc = cyc + 1;
            end
            check("ack_a",    32'(if_a.ack),   32'(e_ack_a));
            check("ack_b",    32'(if_b.ack),   32'(e_ack_b));
            check("err_a",    32'(if_a.err),   32'(e_err_a));
            check("err_b",    32'(if_b.err),   32'(e_err_b));
            check("rdata_a",  if_a.rdata,      m_rdata_a);
            check("rdata_b",  if_b.rdata,      m_rdata_b);
            check("ram_we",   32'(ram_we),     32'(e_we));
            check("ram_addr", 32'(ram_addr),   32'(m_hold_addr));
            check("ram_din",  ram_din,         m_hold_din);
`ifdef RAM1024X32_ARBITER_STATS_EN
            check("gnt_cnt_a", 32'(gnt_cnt_a), 32'(m_cnt_a));
            check("gnt_cnt_b", 32'(gnt_cnt_b), 32'(m_cnt_b));
`endif
            if (!rst_n) begin
                m_busy = 1'b0; m_last = 1'b1; m_free_cyc = cyc + 1;
                m_rdata_a = '0; m_rdata_b = '0; m_hold_addr = '0; m_hold_din = '0;
                m_cnt_a = 0; m_cnt_b = 0;
            end else if (!m_busy && cyc >= m_free_cyc && (if_a.req || if_b.req)) begin
                nb          = (if_a.req && if_b.req) ? !m_last : if_b.req;
                m_last      = nb;
                m_own       = nb;
                m_we        = nb ? if_b.we : if_a.we;
                m_addr      = nb ? if_b.addr : if_a.addr;
                m_wdata     = nb ? if_b.wdata : if_a.wdata;
                m_oor       = (m_addr >= 11'd1024);
                m_busy      = 1'b1;
                m_issue_cyc = cyc + 1;
                m_ack_cyc   = (m_we || m_oor) ? cyc + 2 : cyc + 2 + RD_LAT;
                if (!m_oor) begin
                    if (m_we) model_mem[m_addr[9:0]] = m_wdata;
                    else      m_rdata_res = model_mem[m_addr[9:0]];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [10:0] addr, input logic [31:0] wd);
        if (port) begin
            if_b.req = req; if_b.we = we; if_b.addr = addr; if_b.wdata = wd;
        end else begin
            if_a.req = req; if_a.we = we; if_a.addr = addr; if_a.wdata = wd;
        end
    endtask

    // Issue one command from IDLE and wait for its ack; returns latency and response.
    task automatic do_cmd(input bit port, input bit we, input logic [10:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rdv,
                          output bit er, output int wes);
        int start;
        bit got;
        @(posedge clk); #1;
        drive(port, 1'b1, we, addr, wd);
        start = cyc; wes = 0; got = 1'b0; lat = -1; rdv = '0; er = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (ram_we) wes++;
            if (port ? if_b.ack : if_a.ack) begin
                got = 1'b1;
                lat = cyc - start;
                rdv = port ? if_b.rdata : if_a.rdata;
                er  = port ? if_b.err : if_a.err;
            end
        end
        drive(port, 1'b0, we, addr, wd);
        if (!got) begin
            checks++; errors++;
            $display("FAIL do_cmd_timeout: actual=no ack required=ack within 20 cycles");
        end
    endtask

    // Waits (bounded) for the next ack on either port.
    task automatic wait_ack(output bit who_b, output bit ok);
        ok = 1'b0; who_b = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (if_a.ack || if_b.ack) begin
                ok = 1'b1; who_b = if_b.ack;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_ack_timeout: actual=no ack required=ack within 20 cycles");
        end
    endtask

    function automatic logic [10:0] rand_addr();
        int s;
        s = $urandom_range(0, 9);
        if (s < 6)       return 11'($urandom_range(0, 7));
        else if (s == 6) return 11'd1023;
        else if (s == 7) return 11'd1024;
        else if (s == 8) return 11'd2047;
        else             return 11'($urandom_range(0, 2047));
    endfunction

    task automatic new_cmd(input bit port);
        drive(port, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
    endtask

    task automatic agent(input bit port);
        bit r, a;
        r = port ? if_b.req : if_a.req;
        a = port ? if_b.ack : if_a.ack;
        if (r) begin
            if (a) begin
                if ($urandom_range(0, 1) == 1) new_cmd(port);
                else drive(port, 1'b0, 1'b0, 11'd0, 32'd0);
            end
        end else if ($urandom_range(0, 9) < 4) begin
            new_cmd(port);
        end
    endtask

    // ---------------- main sequence ----------------
    int          lat, wes;
    logic [31:0] rdv;
    bit          er, who_b, ok;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        check("reset_ack_a",    32'(if_a.ack), 32'd0);
        check("reset_ram_we",   32'(ram_we),   32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_rdata_b",  if_b.rdata,    32'd0);

        // Simultaneous writes from reset: A first, then strict alternation.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 11'd10, 32'hA0A0_0010);
        drive(1'b1, 1'b1, 1'b1, 11'd20, 32'hB0B0_0020);
        for (int k = 0; k < 6; k++) begin
            wait_ack(who_b, ok);
            if (ok) check("alternation", 32'(who_b), 32'(k % 2));
        end
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);

        // Write then read back on port A.
        do_cmd(1'b0, 1'b1, 11'd5, 32'hDEADBEEF, lat, rdv, er, wes);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_we_cycles", 32'(wes), 32'd1);
        do_cmd(1'b0, 1'b0, 11'd5, 32'd0, lat, rdv, er, wes);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_data", rdv, 32'hDEADBEEF);

        // Address boundaries.
        do_cmd(1'b1, 1'b1, 11'd1023, 32'h12345678, lat, rdv, er, wes);
        do_cmd(1'b1, 1'b0, 11'd1023, 32'd0, lat, rdv, er, wes);
        check("rd_1023_data", rdv, 32'h12345678);
        check("rd_1023_err", 32'(er), 32'd0);
        do_cmd(1'b0, 1'b1, 11'd1024, 32'hFFFF_0000, lat, rdv, er, wes);
        check("wr_1024_err", 32'(er), 32'd1);
        check("wr_1024_we", 32'(wes), 32'd0);
        check("wr_1024_latency", 32'(lat), 32'd2);
        do_cmd(1'b0, 1'b0, 11'd2047, 32'd0, lat, rdv, er, wes);
        check("rd_2047_data", rdv, 32'd0);
        check("rd_2047_err", 32'(er), 32'd1);

        // Reset during WAIT of a read: no ack, then A wins the next tie.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 11'd5, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_ack_a", 32'(if_a.ack), 32'd0);
        check("rst_wait_err_a", 32'(if_a.err), 32'd0);
        check("rst_wait_ram_we", 32'(ram_we), 32'd0);
        check("rst_wait_rdata_a", if_a.rdata, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 11'd20, 32'd0);
        wait_ack(who_b, ok);
        if (ok) check("rst_then_a_first", 32'(who_b), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        wait_ack(who_b, ok);
        if (ok) check("rst_then_b_second", 32'(who_b), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);

        // Randomized traffic with one mid-run reset pulse.
        for (int t = 0; t < 1500; t++) begin
            @(posedge clk); #1;
            agent(1'b0);
            agent(1'b1);
            rst_n = (t == 700) ? 1'b0 : 1'b1;
        end
        drive(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 11'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
